// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered UART transmitter: a DEPTH-entry byte FIFO feeding an 8N1
//   serializer (8E1 when UART_TX_PARITY_EN is defined). LSB first,
//   idle-high line. Producers can burst up to DEPTH bytes without regard
//   to line timing. Each bit lasts DIVIDER = (CLK*1_000_000)/BAUD cycles.
//
//   Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit
//   after data bit 7 (11 bit times per frame instead of 10).
//
// Ports
//   clk         in   1                 system clock
//   reset       in   1                 synchronous, active-high reset
//   data_ready  out  1                 FIFO can accept a byte this cycle
//   data_valid  in   1                 producer offers data_byte
//   data_byte   in   8                 byte to send
//   pin         out  1                 serial TX line (registered)
//   busy        out  1                 frame in progress or FIFO non-empty
//   count       out  $clog2(DEPTH)+1   FIFO occupancy, 0..DEPTH
module uart_tx_buffered #(
  parameter int CLK   = 0,   // system clock in MHz
  parameter int BAUD  = 0,   // line baud rate
  parameter int DEPTH = 16   // FIFO entries, power of 2, >= 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   data_ready,
  input  logic                   data_valid,
  input  logic [7:0]             data_byte,
  output logic                   pin,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int DIVIDER = (BAUD > 0) ? (CLK * 1_000_000) / BAUD : 0;
  localparam int DIV_W   = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  if (DIVIDER < 2) begin : g_bad_divider
    $error("uart_tx_buffered: DIVIDER = (CLK*1_000_000)/BAUD must be >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               pin_q, pin_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               push, pop, empty, full, tick;
  logic [7:0]         head;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign data_ready = !reset && !full;
  assign push       = data_valid && data_ready;
  assign head       = mem[rd_ptr];
  assign tick       = (baud_q == DIV_W'(DIVIDER - 1));

  assign pin   = pin_q;
  assign count = count_q;
  assign busy  = (state_q != IDLE) || !empty;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pin_d    = pin_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        pin_d  = 1'b1;
        baud_d = '0;
        if (!empty) begin
          // Pop and drive the start bit on the same edge.
          pop      = 1'b1;
          shift_d  = head;
          pin_d    = 1'b0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      START: begin
        if (tick) begin
          baud_d  = '0;
          bit_d   = '0;
          pin_d   = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            pin_d   = parity_q;
            state_d = PARITY;
`else
            pin_d   = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // shift_q[0] is on the line now; bit 1 becomes the next bit.
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            pin_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          baud_d  = '0;
          pin_d   = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          baud_d = '0;
          if (!empty) begin
            // Back-to-back frame: skip IDLE so there is no gap.
            pop      = 1'b1;
            shift_d  = head;
            pin_d    = 1'b0;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            pin_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pin_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      pin_q    <= pin_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is not reset; count and the pointers define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_byte;
  end

endmodule
